// File: rtl/param_editor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : param_editor                                                    |
// | Purpose  : Four-field button-driven parameter editor with commit strobe.   |
// |            Optional idle timeout enabled by macro PARAM_EDITOR_TIMEOUT_EN. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module param_editor #(
    parameter logic [3:0]  MAX0           = 4'd12,
    parameter logic [3:0]  MAX1           = 4'd9,
    parameter logic [3:0]  MAX2           = 4'd9,
    parameter logic [3:0]  MAX3           = 4'd9,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_edit,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ok,
    input  logic [3:0] cur_data0,
    input  logic [3:0] cur_data1,
    input  logic [3:0] cur_data2,
    input  logic [3:0] cur_data3,
    output logic [3:0] edit_data0,
    output logic [3:0] edit_data1,
    output logic [3:0] edit_data2,
    output logic [3:0] edit_data3,
    output logic [1:0] field_sel,
    output logic       editing,
    output logic       set
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EDIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [15:0] RESET_DATA = {4'd5, 4'd1, 4'd3, 4'd10};

    logic [1:0]       state_q, state_d;
    logic [1:0]       field_sel_q, field_sel_d;
    logic [3:0][3:0]  data_q, data_d;
    logic [4:0]       btn_prev_q, btn_prev_d;

    logic [4:0]       btn_now;
    logic [4:0]       btn_edge;
    logic             edge_ok, edge_enter, edge_next, edge_inc, edge_dec;
    logic             edge_field;
    logic             timeout_hit;
    logic [3:0][3:0]  max_vec;
    logic [3:0][3:0]  cur_vec;
    logic [3:0]       sel_max;
    logic [3:0]       sel_val;

    // Bit order {ok, enter, next, inc, dec}; history resets high so held buttons stay silent.
    assign btn_now    = {btn_ok, enter_edit, btn_next, btn_inc, btn_dec};
    assign btn_edge   = btn_now & ~btn_prev_q;
    assign btn_prev_d = btn_now;
    assign {edge_ok, edge_enter, edge_next, edge_inc, edge_dec} = btn_edge;
    assign edge_field = edge_next | edge_inc | edge_dec;

    assign max_vec = {MAX3, MAX2, MAX1, MAX0};
    assign cur_vec = {cur_data3, cur_data2, cur_data1, cur_data0};
    assign sel_max = max_vec[field_sel_q];
    assign sel_val = data_q[field_sel_q];

`ifdef PARAM_EDITOR_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && edge_enter) begin
            cnt_d = 32'd0;
        end else if (state_q == S_EDIT) begin
            cnt_d = edge_field ? 32'd0 : cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q == S_EDIT) && (cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (edge_enter) begin
                    state_d = S_EDIT;
                end
            end
            S_EDIT: begin
                if (edge_ok) begin
                    state_d = S_COMMIT;
                end else if (edge_enter) begin
                    state_d = S_IDLE;
                end else if (timeout_hit && !edge_field) begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        editing = 1'b0;
        set     = 1'b0;
        case (state_q)
            S_EDIT:   editing = 1'b1;
            S_COMMIT: set     = 1'b1;
            default:  ;
        endcase
    end

    // Working-value datapath: ok and enter preempt field edits; inc with dec cancels.
    always_comb begin
        data_d      = data_q;
        field_sel_d = field_sel_q;
        if (state_q == S_IDLE && edge_enter) begin
            for (int i = 0; i < 4; i++) begin
                data_d[i] = (cur_vec[i] > max_vec[i]) ? max_vec[i] : cur_vec[i];
            end
            field_sel_d = 2'd0;
        end else if (state_q == S_EDIT && !edge_ok && !edge_enter) begin
            if (edge_next) begin
                field_sel_d = field_sel_q + 2'd1;
            end else if (edge_inc && !edge_dec) begin
                data_d[field_sel_q] = (sel_val >= sel_max) ? 4'd0 : sel_val + 4'd1;
            end else if (edge_dec && !edge_inc) begin
                data_d[field_sel_q] = (sel_val == 4'd0) ? sel_max : sel_val - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field_sel_q <= 2'd0;
            data_q      <= RESET_DATA;
            btn_prev_q  <= 5'b11111;
        end else begin
            field_sel_q <= field_sel_d;
            data_q      <= data_d;
            btn_prev_q  <= btn_prev_d;
        end
    end

    assign edit_data0 = data_q[0];
    assign edit_data1 = data_q[1];
    assign edit_data2 = data_q[2];
    assign edit_data3 = data_q[3];
    assign field_sel  = field_sel_q;

endmodule
`default_nettype wire
